// File: rtl/key_sched_stream.sv
// Iterative AES-128 round-key generator that streams round keys over valid/ready.
// sub_word computes the S-box arithmetically: GF(2^8) inverse combined with the affine map.

module sub_word (
    input  logic        enc_or_dec_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and it maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] e;
        r = 8'h01;
        e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (e[i]) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a, input logic fwd);
        logic [7:0] v;
        if (fwd) begin
            v = gf_inv(a);
            v = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
        end else begin
            v = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
            v = gf_inv(v);
        end
        return v;
    endfunction

    always_comb begin
        data_o = '0;
        for (int i = 0; i < 4; i++) begin
            data_o[8*i +: 8] = sbox(data_i[8*i +: 8], enc_or_dec_i);
        end
    end
endmodule

module key_sched_stream (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         enc_or_dec_i,
    input  logic [127:0] key_i,
    output logic [127:0] rkey_o,
    output logic [3:0]   round_o,
    output logic         rkey_valid_o,
    input  logic         rkey_ready_i,
    output logic         busy_o,
    output logic         done_o
);
    localparam int unsigned KW = 128;
    localparam int unsigned WW = 32;
    localparam int unsigned RW = 4;
    localparam logic [RW-1:0] LAST_ROUND = 4'd10;

    // The key load happens on the edge that accepts start, so no cycle is spent in a load state.
    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_EMIT} state_t;

    state_t        r_state, w_state;
    logic          r_enc, w_enc;
    logic [KW-1:0] r_rkey, w_rkey;
    logic [RW-1:0] r_round, w_round;
    logic          r_valid, w_valid;
    logic          r_busy, w_busy;
    logic          r_done, w_done;

    logic [WW-1:0] w_w0, w_w1, w_w2, w_w3;
    logic [WW-1:0] w_inv3, w_inv2, w_inv1, w_inv0;
    logic [WW-1:0] w_fwd0, w_fwd1, w_fwd2, w_fwd3;
    logic [WW-1:0] w_sub_in, w_sub_out, w_t;
    logic [KW-1:0] w_fwd_key, w_inv_key;
    logic [RW-1:0] w_rcon_idx;
    logic          w_inverse, w_hs, w_final;

    function automatic logic [7:0] rcon(input logic [RW-1:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign w_w0 = r_rkey[127:96];
    assign w_w1 = r_rkey[95:64];
    assign w_w2 = r_rkey[63:32];
    assign w_w3 = r_rkey[31:0];

    // The single sub_word is shared: the inverse step substitutes the recovered w3.
    assign w_inverse  = (r_state == S_EMIT) && !r_enc;
    assign w_inv3     = w_w3 ^ w_w2;
    assign w_inv2     = w_w2 ^ w_w1;
    assign w_inv1     = w_w1 ^ w_w0;
    assign w_sub_in   = w_inverse ? w_inv3 : w_w3;
    assign w_rcon_idx = w_inverse ? r_round : RW'(r_round + 4'd1);

    sub_word u_sub_word (
        .enc_or_dec_i (1'b1),
        .data_i       ({w_sub_in[23:0], w_sub_in[31:24]}),
        .data_o       (w_sub_out)
    );

    assign w_t    = w_sub_out ^ {rcon(w_rcon_idx), 24'h000000};
    assign w_fwd0 = w_w0 ^ w_t;
    assign w_fwd1 = w_w1 ^ w_fwd0;
    assign w_fwd2 = w_w2 ^ w_fwd1;
    assign w_fwd3 = w_w3 ^ w_fwd2;
    assign w_inv0 = w_w0 ^ w_t;

    assign w_fwd_key = {w_fwd0, w_fwd1, w_fwd2, w_fwd3};
    assign w_inv_key = {w_inv0, w_inv1, w_inv2, w_inv3};

    assign w_hs    = r_valid && rkey_ready_i;
    assign w_final = r_enc ? (r_round == LAST_ROUND) : (r_round == 4'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_enc   <= 1'b0;
            r_rkey  <= '0;
            r_round <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_enc   <= w_enc;
            r_rkey  <= w_rkey;
            r_round <= w_round;
            r_valid <= w_valid;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_state = r_state;
        w_enc   = r_enc;
        w_rkey  = r_rkey;
        w_round = r_round;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_enc   = enc_or_dec_i;
                    w_rkey  = key_i;
                    w_round = '0;
                    w_state = enc_or_dec_i ? S_EMIT : S_EXPAND;
                end
            end
            S_EXPAND: begin
                w_rkey  = w_fwd_key;
                w_round = RW'(r_round + 4'd1);
                if (r_round == 4'd9) w_state = S_EMIT;
            end
            S_EMIT: begin
                if (w_hs) begin
                    if (w_final) begin
                        w_state = S_IDLE;
                        w_done  = 1'b1;
                    end else if (r_enc) begin
                        w_rkey  = w_fwd_key;
                        w_round = RW'(r_round + 4'd1);
                    end else begin
                        w_rkey  = w_inv_key;
                        w_round = RW'(r_round - 4'd1);
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
        w_valid = (w_state == S_EMIT);
        w_busy  = (w_state != S_IDLE);
    end

    assign rkey_o       = r_rkey;
    assign round_o      = r_round;
    assign rkey_valid_o = r_valid;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
endmodule

// File: tb/tb_key_sched_stream.sv
// Bench for key_sched_stream: FIPS-197 vectors plus randomized streams checked against
// a word-array key expansion model with a table-generated S-box.

module tb_key_sched_stream;
    logic         clk = 1'b0;
    logic         rst_i, start_i, enc_or_dec_i, rkey_ready_i;
    logic [127:0] key_i, rkey_o;
    logic [3:0]   round_o;
    logic         rkey_valid_o, busy_o, done_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox [256];
    logic [127:0] exp_keys [11];
    logic [127:0] got_keys [11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    typedef struct {
        int           round;
        logic [127:0] key;
    } kvec_t;
    kvec_t tbl [4];

    always #5 clk = ~clk;

    key_sched_stream dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .enc_or_dec_i (enc_or_dec_i),
        .key_i        (key_i),
        .rkey_o       (rkey_o),
        .round_o      (round_o),
        .rkey_valid_o (rkey_valid_o),
        .rkey_ready_i (rkey_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Classic generator walk: p steps through GF(2^8)* by x3, q tracks its inverse.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Starts a run from an IDLE cycle and returns in the cycle where done_o should be high.
    task automatic run_stream(input logic enc, input logic [127:0] key, input bit rnd, input bit inject);
        int           idx, first_c, exp_round;
        bit           stalled, finished;
        logic [127:0] h_key;
        logic [3:0]   h_round;
        expand(key);
        start_i      = 1'b1;
        enc_or_dec_i = enc;
        key_i        = key;
        tick();
        idx = 0; first_c = 0; stalled = 1'b0; finished = 1'b0;
        h_key = '0; h_round = '0;
        for (int c = 1; c <= 300 && !finished; c++) begin
            start_i = 1'b0;
            if (inject && (c == 5 || c == (enc ? 7 : 13))) begin
                start_i      = 1'b1;
                enc_or_dec_i = ~enc;
                key_i        = ~key;
            end
            rkey_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            check("busy_in_stream", 128'(busy_o), 128'd1);
            check("done_in_stream", 128'(done_o), 128'd0);
            if (stalled) begin
                check("stall_valid", 128'(rkey_valid_o), 128'd1);
                check("stall_round", 128'(round_o), 128'(h_round));
                check("stall_key", rkey_o, h_key);
            end
            if (rkey_valid_o && first_c == 0) first_c = c;
            if (rkey_valid_o && rkey_ready_i) begin
                exp_round = enc ? idx : 10 - idx;
                check("round", 128'(round_o), 128'(exp_round));
                check("rkey", rkey_o, exp_keys[exp_round]);
                got_keys[exp_round] = rkey_o;
                idx++;
                if (idx == 11) finished = 1'b1;
            end
            stalled = rkey_valid_o && !rkey_ready_i;
            h_round = round_o;
            h_key   = rkey_o;
            tick();
        end
        start_i      = 1'b0;
        rkey_ready_i = 1'b0;
        check("handshakes", 128'(idx), 128'd11);
        check("first_valid_cycle", 128'(first_c), enc ? 128'd1 : 128'd11);
        check("done_pulse", 128'(done_o), 128'd1);
        check("busy_after_done", 128'(busy_o), 128'd0);
        check("valid_after_done", 128'(rkey_valid_o), 128'd0);
    endtask

    task automatic idle_gap();
        tick();
        check("done_one_cycle", 128'(done_o), 128'd0);
        tick();
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 4; i++) check(tag, got_keys[tbl[i].round], tbl[i].key);
    endtask

    task automatic reset_mid_emit();
        bit found;
        found = 1'b0;
        expand(FIPS_KEY);
        start_i      = 1'b1;
        enc_or_dec_i = 1'b1;
        key_i        = FIPS_KEY;
        tick();
        start_i      = 1'b0;
        rkey_ready_i = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (rkey_valid_o && round_o == 4'd5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("reached_round5", 128'(found), 128'd1);
        rst_i = 1'b1;
        tick();
        check("rst_rkey", rkey_o, 128'd0);
        check("rst_round", 128'(round_o), 128'd0);
        check("rst_valid", 128'(rkey_valid_o), 128'd0);
        check("rst_busy", 128'(busy_o), 128'd0);
        check("rst_done", 128'(done_o), 128'd0);
        rst_i        = 1'b0;
        rkey_ready_i = 1'b0;
        tick();
        check("post_rst_busy", 128'(busy_o), 128'd0);
        check("post_rst_valid", 128'(rkey_valid_o), 128'd0);
    endtask

    initial begin
        logic [127:0] rk;
        rst_i = 1'b1; start_i = 1'b0; enc_or_dec_i = 1'b0; key_i = '0; rkey_ready_i = 1'b0;
        build_sbox();
        tbl[0] = '{0,  FIPS_KEY};
        tbl[1] = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
        tbl[2] = '{2,  128'hf2c295f27a96b9435935807a7359f67f};
        tbl[3] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tick();
        tick();
        check("reset_rkey", rkey_o, 128'd0);
        check("reset_round", 128'(round_o), 128'd0);
        check("reset_valid", 128'(rkey_valid_o), 128'd0);
        check("reset_busy", 128'(busy_o), 128'd0);
        check("reset_done", 128'(done_o), 128'd0);
        rst_i = 1'b0;
        tick();

        run_stream(1'b1, FIPS_KEY, 1'b0, 1'b0);
        check_table("fips_enc");
        idle_gap();
        run_stream(1'b0, FIPS_KEY, 1'b0, 1'b0);
        check_table("fips_dec");
        idle_gap();

        run_stream(1'b1, FIPS_KEY, 1'b1, 1'b0);
        idle_gap();
        run_stream(1'b0, FIPS_KEY, 1'b1, 1'b0);
        idle_gap();
        for (int i = 0; i < 6; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            run_stream(1'($urandom_range(0, 1)), rk, 1'b1, 1'b0);
            idle_gap();
        end

        run_stream(1'b0, FIPS_KEY, 1'b0, 1'b1);
        idle_gap();
        run_stream(1'b1, FIPS_KEY, 1'b1, 1'b1);
        idle_gap();

        reset_mid_emit();
        run_stream(1'b0, FIPS_KEY, 1'b0, 1'b0);
        idle_gap();

        run_stream(1'b1, FIPS_KEY, 1'b0, 1'b0);
        rk = {$urandom, $urandom, $urandom, $urandom};
        run_stream(1'b1, rk, 1'b1, 1'b0);
        idle_gap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/key_sched_stream.md
# key_sched_stream

Iterative AES-128 round-key generator that streams the eleven round keys to the cipher datapath over a valid/ready handshake. It emits rounds 0→10 for encryption and rounds 10→0 for decryption; for decryption it first runs the forward schedule to round 10, then walks back with the inverse key-schedule step. Each step instantiates one `sub_word` with `enc_or_dec_i` tied to 1, because both schedule directions use the forward S-box. The block sits between the key input register and the round engines, replacing a precomputed 1408-bit key table.

## Interface
Parameters: none.
- `clk_i`  input  1  — single clock; all state updates on the rising edge.
- `rst_i`  input  1  — reset, synchronous, active-high.
- `start_i`  input  1  — begin a schedule; sampled only in IDLE.
- `enc_or_dec_i`  input  1  — 1 = encrypt order (0→10), 0 = decrypt order (10→0); latched on accepted start.
- `key_i`  input  128  — cipher key, latched on accepted start; `w0` = `[127:96]`.
- `rkey_o`  output  128  — current round key.
- `round_o`  output  4  — round index of `rkey_o` (0..10).
- `rkey_valid_o`  output  1  — `rkey_o`/`round_o` are valid.
- `rkey_ready_i`  input  1  — consumer accepts the key when `rkey_valid_o && rkey_ready_i`.
- `busy_o`  output  1  — high in every state other than IDLE.
- `done_o`  output  1  — one-cycle pulse after the final key handshake.

## Operation
- **States:**
  - IDLE → LOAD on `start_i`.
  - LOAD → EMIT if `enc_or_dec_i` = 1; LOAD → EXPAND if `enc_or_dec_i` = 0.
  - EXPAND → EMIT after round 10 is computed.
  - EMIT → IDLE on the final handshake.
- **Start:** `start_i` is ignored outside IDLE.
- **LOAD:** `rkey_o` ← `key_i`, `round_o` ← 0.
- **Words:** `rkey_o` = {`w0`, `w1`, `w2`, `w3`}.
- **RotWord:** `{b0,b1,b2,b3}` → `{b1,b2,b3,b0}`.
- **Rcon:** `Rcon[r]` for r = 1..10 = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36, placed in bits `[31:24]` of a 32-bit word with the low 24 bits zero.
- **Forward step (r-1 → r):**
  - `t = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}`
  - `w0' = w0 ^ t`, `w1' = w1 ^ w0'`, `w2' = w2 ^ w1'`, `w3' = w3 ^ w2'`
- **Inverse step (r → r-1):**
  - `w3' = w3 ^ w2`, `w2' = w2 ^ w1`, `w1' = w1 ^ w0`
  - `w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[r], 24'h0}`
- **EXPAND:** applies one forward step per cycle for r = 1..10. `round_o` tracks r. `rkey_valid_o` stays 0 throughout.
- **EMIT:**
  - `rkey_valid_o` = 1.
  - On a handshake, the register takes the next key: forward step in encrypt mode, inverse step in decrypt mode. `round_o` moves ±1.
  - Final key: round 10 (encrypt) or round 0 (decrypt). Its handshake moves the block to IDLE with `done_o` = 1 for one cycle.
- **Datapath sharing:** a single `sub_word` instance serves both steps. Its input is muxed: `w3` in EXPAND/encrypt, `w3'` (inverse) in decrypt EMIT.
- **Round counter:** `round_o` never wraps. Stepping beyond 0 or 10 is impossible by construction.
- **Reset in any state:** IDLE next cycle, all outputs 0, any pending key discarded.

## Timing
- **Reset values:** `rkey_o` = 0, `round_o` = 0, `rkey_valid_o` = 0, `busy_o` = 0, `done_o` = 0.
- **Start:** accepted at edge E.
  - LOAD is complete after E; `busy_o` = 1 from E+1.
  - Encrypt: `rkey_valid_o` = 1 with round 0 from E+1.
  - Decrypt: forward steps at edges E+1..E+10; `rkey_valid_o` = 1 with round 10 from E+11.
- **Throughput:** one key per cycle while `rkey_ready_i` is held high; no bubbles between keys.
- **Backpressure:** while `rkey_valid_o` = 1 and `rkey_ready_i` = 0, `rkey_o` and `round_o` are held stable.
- **Completion:** final handshake at edge F → `done_o` = 1 and `busy_o` = 0 during cycle F+1.
  - A new `start_i` is accepted at edge F+1 at the earliest.
- **Start while busy:** no effect; latched mode and key are unchanged.

## Test plan
Key for all scenarios: `2b7e151628aed2a6abf7158809cf4f3c` (FIPS-197).
1. **Encrypt, `rkey_ready_i` held 1:**
   - Rounds 0, 1, 2, …, 10 are emitted on consecutive cycles.
   - Round 1 = `a0fafe1788542cb123a339392a6c7605`.
   - Round 2 = `f2c295f27a96b9435935807a7359f67f`.
   - Round 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`.
   - `done_o` pulses once.
2. **Decrypt, `rkey_ready_i` held 1:**
   - First valid key appears 11 cycles after start, as round 10 = `d014f9a8…0ca6`.
   - Round 1 = `a0fafe17…6c7605`.
   - Final key is round 0 = `key_i`.
   - 11 handshakes in total.
3. **Random `rkey_ready_i` (≈50 %), both modes:**
   - `rkey_o` and `round_o` are stable during every stall.
   - The sequence matches scenarios 1 and 2 exactly.
4. **Start pulsed in EXPAND and in EMIT with a different key and mode:** ignored; the output stream is unchanged.
5. **Reset:**
   - `rst_i` asserted mid-EMIT (encrypt, round 5) → next cycle all outputs are 0 and the block is in IDLE.
   - A fresh decrypt start then completes correctly.
6. **Back-to-back runs:** `start_i` asserted on the cycle `done_o` is high → accepted, and a second full encrypt stream follows.
